serial_rx_param: RTL

Parametrised UART receiver: the next generation of the team's fixed 8N1 serial receiver. It adds configurable divider, data width and stop-bit count, optional parity checking, start-bit validation, framing-error and break detection, and a valid/ready output handshake with overrun reporting. It sits between the asynchronous `rx` pin and the command/display logic, in the single system clock domain.

---
 rtl/serial_rx_param_if.sv | 12 +
 rtl/serial_rx_param.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_rx_param_if.sv
// Output handshake bundle of serial_rx_param: received word, parity flag, valid/ready.
interface serial_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, rx_perr, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_perr, rx_valid, output rx_ready);
endinterface

// File: rtl/serial_rx_param.sv
// Parametrised UART receiver with framing/break detection and valid/ready output.
// Define SERIAL_RX_PARITY_EN to expect and check one parity bit after the data bits.
module serial_rx_param #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  serial_rx_param_if.master rxif,
  output logic frame_err,
  output logic break_det,
  output logic overrun,
  output logic busy
);
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  if (CLK_DIV < 4 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("serial_rx_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 s1, rxs;
  logic [15:0]          cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 any_one;    // a 1 was seen in data/parity: frame cannot be a break
  logic                 stop0_low;
  logic                 first_low, stop_low, perr_v;

`ifdef SERIAL_RX_PARITY_EN
  logic perr;
  assign perr_v = perr;
`else
  assign perr_v = 1'b0;
`endif

  // Evaluated at the last stop sample; with two stop bits the first was captured earlier.
  assign first_low = (STOP_BITS == 1) ? !rxs : stop0_low;
  assign stop_low  = first_low | !rxs;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      s1            <= 1'b1;
      rxs           <= 1'b1;
      cnt           <= '0;
      shreg         <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      any_one       <= 1'b0;
      stop0_low     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr          <= 1'b0;
`endif
      rxif.rx_data  <= '0;
      rxif.rx_perr  <= 1'b0;
      rxif.rx_valid <= 1'b0;
      frame_err     <= 1'b0;
      break_det     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      s1        <= rx;
      rxs       <= s1;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= (cnt == LAST) ? '0 : cnt + 16'd1;
      if (rxif.rx_valid && rxif.rx_ready) rxif.rx_valid <= 1'b0;

      case (state)
        IDLE: if (!rxs) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == HALF - 16'd1) begin
          cnt <= '0;
          if (rxs) state <= IDLE;
          else begin
            state   <= DATA;
            bit_idx <= '0;
            any_one <= 1'b0;
          end
        end
        DATA: if (cnt == LAST) begin
          shreg   <= {rxs, shreg[DATA_BITS-1:1]};
          any_one <= any_one | rxs;
          if (bit_idx == 4'(DATA_BITS - 1)) begin
            stop_idx <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            state    <= PARITY;
`else
            state    <= STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 4'd1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: if (cnt == LAST) begin
          perr    <= ((^shreg) ^ rxs) != 1'(PARITY_ODD);
          any_one <= any_one | rxs;
          state   <= STOP;
        end
`endif
        STOP: if (cnt == LAST) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            if (!stop_low) begin
              state <= IDLE;
              if (!rxif.rx_valid || rxif.rx_ready) begin
                rxif.rx_data  <= shreg;
                rxif.rx_perr  <= perr_v;
                rxif.rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state <= WAIT_HIGH;
              if (!any_one && first_low) break_det <= 1'b1;
              else                       frame_err <= 1'b1;
            end
          end else begin
            stop_idx  <= 1'b1;
            stop0_low <= !rxs;
          end
        end
        WAIT_HIGH: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
